bitflip_monitor_mc: RTL and testbench

Multi-channel, windowed bitflip monitor. Counts cycles with any bitflip, total flipped bits, peak flips per cycle and per-channel flips over a programmable sample window. At each window end it snapshots the results and raises threshold interrupts. Sits beside the protected memory or logic array; software configures and reads it over the team's simple valid/ready register bus.

---
 rtl/bitflip_monitor_pkg.sv | 10 +
 rtl/bitflip_monitor_mc_popcount.sv | 13 +
 rtl/bitflip_monitor_mc.sv | 171 +++++++++++++++++
 tb/tb_bitflip_monitor_mc.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitflip_monitor_pkg.sv
// bitflip_monitor_pkg: shared types, register map and constants for the bitflip monitor.
package bitflip_monitor_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int unsigned A_CTRL = 0, A_WIN = 1, A_THR_CYC = 2, A_THR_BITS = 3, A_STATUS = 4;
  localparam int unsigned A_HIT = 5, A_BIT = 6, A_PEAK = 7, A_CH = 8;
  localparam logic [31:0] WIN_LEN_RST = 32'd1000, THR_CYC_RST = 32'd100, THR_BITS_RST = 32'd1000;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
  localparam int CTRL_EN = 0, CTRL_CLR = 1, CTRL_IEC = 2, CTRL_IEB = 3;
  localparam int ST_IRQ_CYC = 0, ST_IRQ_BITS = 1, ST_WIN_DONE = 2;
endpackage

// File: rtl/bitflip_monitor_mc_popcount.sv
// bitflip_popcount: combinational population count of a W-bit vector.
module bitflip_popcount #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt += CW'(bits[i]);
  end
endmodule

// File: rtl/bitflip_monitor_mc.sv
// bitflip_monitor_mc: windowed multi-channel bitflip statistics with snapshots,
// threshold interrupts and a valid/ready register interface.
module bitflip_monitor_mc
  import bitflip_monitor_pkg::*;
#(
  parameter int IN_WIDTH   = 64,
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [IN_WIDTH-1:0]   value_i,
  input  logic                  bus_valid_i,
  input  logic                  bus_we_i,
  input  logic [ADDR_WIDTH-1:0] bus_addr_i,
  input  logic [DATA_WIDTH-1:0] bus_wdata_i,
  output logic [DATA_WIDTH-1:0] bus_rdata_o,
  output logic                  bus_ready_o,
  output logic                  bus_error_o,
  output logic                  interr_o
);
  localparam int CH_W = IN_WIDTH / NUM_CH;
  localparam int CPW  = $clog2(CH_W + 1);
  localparam int PW   = $clog2(IN_WIDTH + 1);
  state_t state, state_n;
  logic [IN_WIDTH-1:0] in_q;
  logic [CPW-1:0] cpop [NUM_CH];
  logic [PW-1:0] pop;
  logic [DATA_WIDTH-1:0] win_len, thr_cyc, thr_bits, win_cnt, rd;
  logic [CNT_W-1:0] hit_acc, bit_acc, peak_acc, hit_n, bit_n, peak_n, hit_snap, bit_snap, peak_snap;
  logic [CNT_W-1:0] ch_acc [NUM_CH];
  logic [CNT_W-1:0] ch_n [NUM_CH];
  logic [CNT_W-1:0] ch_snap [NUM_CH];
  logic en, ie_cyc, ie_bits, irq_cyc, irq_bits, win_done;
  logic [15:0] win_count;
  logic run_ok, acc_go, win_end, set_cyc, set_bits, err, wr, clr;
  logic [31:0] a;
  logic [2:0] w1c;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
    logic [CNT_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bitflip_popcount #(.W(CH_W)) u_pop (.bits(in_q[c*CH_W +: CH_W]), .cnt(cpop[c]));
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CH; c++) pop += PW'(cpop[c]);
    hit_n  = sat_add(hit_acc, CNT_W'(|pop));
    bit_n  = sat_add(bit_acc, CNT_W'(pop));
    peak_n = CNT_W'(pop) > peak_acc ? CNT_W'(pop) : peak_acc;
    for (int c = 0; c < NUM_CH; c++) ch_n[c] = sat_add(ch_acc[c], CNT_W'(cpop[c]));
  end

  // A shortened WINDOW_LEN ends the current window at once via >=.
  always_comb begin
    run_ok   = en && (win_len != '0);
    state_n  = run_ok ? RUN : IDLE;
    acc_go   = (state == RUN) && run_ok;
    win_end  = acc_go && (win_cnt >= win_len - 1'b1);
    set_cyc  = win_end && (DATA_WIDTH'(hit_n) > thr_cyc);
    set_bits = win_end && (DATA_WIDTH'(bit_n) > thr_bits);
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else state <= state_n;

  always_comb begin
    a   = 32'(bus_addr_i);
    err = bus_valid_i && (a >= A_CH + NUM_CH || (bus_we_i && a >= A_HIT));
    wr  = bus_valid_i && bus_we_i && !err;
    clr = wr && a == A_CTRL && bus_wdata_i[CTRL_CLR];
    w1c = (wr && a == A_STATUS) ? bus_wdata_i[2:0] : 3'b0;
    rd  = '0;
    case (a)
      A_CTRL:     rd = DATA_WIDTH'({ie_bits, ie_cyc, 1'b0, en});
      A_WIN:      rd = win_len;
      A_THR_CYC:  rd = thr_cyc;
      A_THR_BITS: rd = thr_bits;
      A_STATUS:   rd = DATA_WIDTH'({win_count, 13'b0, win_done, irq_bits, irq_cyc});
      A_HIT:      rd = DATA_WIDTH'(hit_snap);
      A_BIT:      rd = DATA_WIDTH'(bit_snap);
      A_PEAK:     rd = DATA_WIDTH'(peak_snap);
      default:    for (int c = 0; c < NUM_CH; c++) if (a == A_CH + 32'(c)) rd = DATA_WIDTH'(ch_snap[c]);
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      en          <= 1'b0;
      ie_cyc      <= 1'b0;
      ie_bits     <= 1'b0;
      win_len     <= DATA_WIDTH'(WIN_LEN_RST);
      thr_cyc     <= DATA_WIDTH'(THR_CYC_RST);
      thr_bits    <= DATA_WIDTH'(THR_BITS_RST);
      bus_rdata_o <= '0;
      bus_ready_o <= 1'b0;
      bus_error_o <= 1'b0;
      interr_o    <= 1'b0;
    end else begin
      bus_ready_o <= bus_valid_i && !err;
      bus_error_o <= err;
      bus_rdata_o <= err ? DATA_WIDTH'(ERR_DATA) : (bus_valid_i && !bus_we_i) ? rd : '0;
      interr_o    <= (irq_cyc && ie_cyc) || (irq_bits && ie_bits);
      if (wr && a == A_CTRL) begin
        en      <= bus_wdata_i[CTRL_EN];
        ie_cyc  <= bus_wdata_i[CTRL_IEC];
        ie_bits <= bus_wdata_i[CTRL_IEB];
      end
      if (wr && a == A_WIN) win_len <= bus_wdata_i;
      if (wr && a == A_THR_CYC) thr_cyc <= bus_wdata_i;
      if (wr && a == A_THR_BITS) thr_bits <= bus_wdata_i;
    end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      in_q      <= '0;
      win_cnt   <= '0;
      hit_acc   <= '0;
      bit_acc   <= '0;
      peak_acc  <= '0;
      hit_snap  <= '0;
      bit_snap  <= '0;
      peak_snap <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ch_acc[c]  <= '0;
        ch_snap[c] <= '0;
      end
      irq_cyc   <= 1'b0;
      irq_bits  <= 1'b0;
      win_done  <= 1'b0;
      win_count <= '0;
    end else begin
      in_q <= value_i;
      if (clr || !acc_go || win_end) begin
        win_cnt  <= '0;
        hit_acc  <= '0;
        bit_acc  <= '0;
        peak_acc <= '0;
        for (int c = 0; c < NUM_CH; c++) ch_acc[c] <= '0;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        hit_acc  <= hit_n;
        bit_acc  <= bit_n;
        peak_acc <= peak_n;
        for (int c = 0; c < NUM_CH; c++) ch_acc[c] <= ch_n[c];
      end
      if (clr) begin
        hit_snap  <= '0;
        bit_snap  <= '0;
        peak_snap <= '0;
        for (int c = 0; c < NUM_CH; c++) ch_snap[c] <= '0;
      end else if (win_end) begin
        hit_snap  <= hit_n;
        bit_snap  <= bit_n;
        peak_snap <= peak_n;
        for (int c = 0; c < NUM_CH; c++) ch_snap[c] <= ch_n[c];
      end
      irq_cyc   <= !clr && (set_cyc || (irq_cyc && !w1c[ST_IRQ_CYC]));
      irq_bits  <= !clr && (set_bits || (irq_bits && !w1c[ST_IRQ_BITS]));
      win_done  <= !clr && (win_end || (win_done && !w1c[ST_WIN_DONE]));
      win_count <= clr ? 16'd0 : win_count + 16'(win_end);
    end
endmodule

// File: tb/tb_bitflip_monitor_mc.sv
// tb_bitflip_monitor_mc: table-driven register checks plus directed window sequences.
module tb_bitflip_monitor_mc;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [63:0] value = '0;
  logic bus_valid = 1'b0, bus_we = 1'b0;
  logic [3:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic bus_ready, bus_error, interr;
  int checks = 0, errs = 0;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ok;
  } vec_t;
  vec_t tbl[$];
  logic [63:0] pq[$];
  logic [31:0] dflt [12];

  bitflip_monitor_mc dut (
    .clk_i(clk), .rstn_i(rstn), .value_i(value),
    .bus_valid_i(bus_valid), .bus_we_i(bus_we), .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata),
    .bus_rdata_o(bus_rdata), .bus_ready_o(bus_ready), .bus_error_o(bus_error), .interr_o(interr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [3:0] ad, input logic [31:0] wd,
                     output logic [31:0] rd, output logic [1:0] st);
    @(negedge clk);
    bus_valid = 1'b1; bus_we = we; bus_addr = ad; bus_wdata = wd;
    @(posedge clk);
    #1;
    bus_valid = 1'b0; bus_we = 1'b0;
    rd = bus_rdata;
    st = {bus_ready, bus_error};
  endtask

  task automatic wr(input logic [3:0] ad, input logic [31:0] wd);
    logic [31:0] r;
    logic [1:0] s;
    bus(1'b1, ad, wd, r, s);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] ad, input logic [31:0] exp);
    logic [31:0] r;
    logic [1:0] s;
    bus(1'b0, ad, 32'd0, r, s);
    chk(nm, r, exp);
    chk({nm, "_resp"}, 32'(s), 32'b10);
  endtask

  task automatic rd_bits(input string nm, input logic [3:0] ad, input logic [31:0] mask, input logic [31:0] exp);
    logic [31:0] r;
    logic [1:0] s;
    bus(1'b0, ad, 32'd0, r, s);
    chk(nm, r & mask, exp);
  endtask

  // Each element is seen by the DUT at the next rising edge; a trailing zero follows.
  task automatic play();
    for (int i = 0; i < pq.size(); i++) begin
      @(negedge clk);
      value = pq[i];
    end
    @(negedge clk);
    value = '0;
  endtask

  function automatic void add(input logic we, input logic [3:0] ad, input logic [31:0] wd,
                              input logic [31:0] rd, input logic ok);
    vec_t t;
    t.we = we; t.addr = ad; t.wdata = wd; t.rdata = rd; t.ok = ok;
    tbl.push_back(t);
  endfunction

  task automatic run_tbl(input string tag);
    logic [31:0] r;
    logic [1:0] s;
    for (int i = 0; i < tbl.size(); i++) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, r, s);
      chk($sformatf("%s%0d_data", tag, i), r, tbl[i].rdata);
      chk($sformatf("%s%0d_resp", tag, i), 32'(s), tbl[i].ok ? 32'b10 : 32'b01);
    end
  endtask

  initial begin
    dflt = '{32'd0, 32'd1000, 32'd100, 32'd1000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 12; i++) add(1'b0, 4'(i), 32'd0, dflt[i], 1'b1);
    add(1'b0, 4'd12, 32'd0, 32'hDEADBEEF, 1'b0);
    add(1'b0, 4'd15, 32'd0, 32'hDEADBEEF, 1'b0);
    add(1'b1, 4'd5, 32'd7, 32'hDEADBEEF, 1'b0);
    add(1'b1, 4'd8, 32'd7, 32'hDEADBEEF, 1'b0);
    add(1'b1, 4'd11, 32'd7, 32'hDEADBEEF, 1'b0);
    add(1'b1, 4'd2, 32'h55, 32'd0, 1'b1);
    add(1'b0, 4'd2, 32'd0, 32'h55, 1'b1);
    add(1'b1, 4'd2, 32'd100, 32'd0, 1'b1);
    add(1'b0, 4'd5, 32'd0, 32'd0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("reset_interr", 32'(interr), 32'd0);
    run_tbl("rst");

    // basic window
    wr(4'd1, 32'd10);
    wr(4'd0, 32'd1);
    pq = '{64'h3, 64'h3, 64'h3, 64'h3, 64'h1_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    play();
    wr(4'd0, 32'd0);
    rd_chk("basic_hit", 4'd5, 32'd5);
    rd_chk("basic_bits", 4'd6, 32'd9);
    rd_chk("basic_peak", 4'd7, 32'd2);
    rd_chk("basic_ch0", 4'd8, 32'd8);
    rd_chk("basic_ch1", 4'd9, 32'd0);
    rd_chk("basic_ch2", 4'd10, 32'd1);
    rd_chk("basic_ch3", 4'd11, 32'd0);
    rd_chk("basic_status", 4'd4, 32'h0001_0004);
    begin
      logic [31:0] r;
      logic [1:0] s;
      bus(1'b1, 4'd5, 32'h1234, r, s);
      chk("ro_write_data", r, 32'hDEADBEEF);
      chk("ro_write_resp", 32'(s), 32'b01);
    end
    rd_chk("ro_write_hit_kept", 4'd5, 32'd5);

    // interrupt above threshold
    wr(4'd0, 32'd2);
    wr(4'd2, 32'd4);
    wr(4'd1, 32'd10);
    wr(4'd0, 32'd5);
    pq = '{64'h1, 64'h1, 64'h1, 64'h1, 64'h1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    play();
    @(posedge clk);
    #1;
    chk("irq_lag_interr", 32'(interr), 32'd0);
    @(posedge clk);
    #1;
    chk("irq_interr", 32'(interr), 32'd1);
    wr(4'd0, 32'd4);
    rd_chk("irq_status", 4'd4, 32'h0001_0005);
    wr(4'd4, 32'd1);
    rd_chk("irq_w1c_status", 4'd4, 32'h0001_0004);
    chk("irq_w1c_interr", 32'(interr), 32'd0);

    // exactly at threshold: no interrupt
    wr(4'd0, 32'd2);
    wr(4'd0, 32'd5);
    pq = '{64'h1, 64'h1, 64'h1, 64'h1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    play();
    wr(4'd0, 32'd4);
    rd_chk("thr_eq_status", 4'd4, 32'h0001_0004);
    rd_chk("thr_eq_hit", 4'd5, 32'd4);
    chk("thr_eq_interr", 32'(interr), 32'd0);

    // back-to-back windows
    wr(4'd0, 32'd2);
    wr(4'd1, 32'd3);
    wr(4'd0, 32'd1);
    pq = {};
    repeat (9) pq.push_back('1);
    play();
    wr(4'd0, 32'd0);
    rd_chk("b2b_status", 4'd4, 32'h0003_0004);
    rd_chk("b2b_hit", 4'd5, 32'd3);
    rd_chk("b2b_bits", 4'd6, 32'd192);
    rd_chk("b2b_peak", 4'd7, 32'd64);
    rd_chk("b2b_ch3", 4'd11, 32'd48);

    // disable mid-window keeps old snapshots and discards the partial
    wr(4'd1, 32'd100);
    wr(4'd0, 32'd1);
    pq = {};
    repeat (5) pq.push_back('1);
    play();
    wr(4'd0, 32'd0);
    rd_chk("dis_bits", 4'd6, 32'd192);
    rd_chk("dis_status", 4'd4, 32'h0003_0004);
    wr(4'd1, 32'd3);
    wr(4'd0, 32'd1);
    pq = '{64'h1, 64'h0, 64'h0};
    play();
    wr(4'd0, 32'd0);
    rd_chk("dis_next_bits", 4'd6, 32'd1);
    rd_chk("dis_next_hit", 4'd5, 32'd1);
    rd_chk("dis_next_status", 4'd4, 32'h0004_0004);

    // W1C colliding with a hardware set: every cycle ends a window
    wr(4'd0, 32'd2);
    wr(4'd2, 32'd0);
    wr(4'd1, 32'd1);
    @(negedge clk);
    value = 64'h1;
    wr(4'd0, 32'd1);
    repeat (3) @(posedge clk);
    wr(4'd4, 32'd7);
    rd_bits("w1c_collide", 4'd4, 32'h7, 32'h5);

    // clear on a window-end cycle wins
    wr(4'd0, 32'd2);
    @(negedge clk);
    value = '0;
    rd_chk("clr_status", 4'd4, 32'd0);
    rd_chk("clr_hit", 4'd5, 32'd0);
    rd_chk("clr_bits", 4'd6, 32'd0);
    rd_chk("clr_ch0", 4'd8, 32'd0);
    chk("clr_interr", 32'(interr), 32'd0);

    // async reset while running
    wr(4'd1, 32'd5);
    @(negedge clk);
    value = '1;
    wr(4'd0, 32'd13);
    repeat (12) @(posedge clk);
    #2;
    chk("pre_reset_interr", 32'(interr), 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_reset_interr", 32'(interr), 32'd0);
    @(negedge clk);
    value = '0;
    rstn = 1'b1;
    run_tbl("arst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
